// File: rtl/uart_recv.sv
// uart_recv: 8N1 serial receiver (optional parity bit), 16x oversampled with a
// 2-of-3 majority vote per bit. Each received byte is handed to the consumer
// on a ready/ack handshake.
//
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the data
// bits and the stop bit. The result of the parity check is reported on
// parity_errH. PARITY_ODD selects odd parity; without the macro it is unused.
//
// Ports:
//   sys_clk        in   master clock, rising edge
//   sys_rst_I      in   synchronous active-low reset
//   uart_REC_dataH in   asynchronous serial line, idle high
//   rec_ackH       in   consumer acknowledge (pulse or level)
//   rec_dataH      out  received byte, valid while rec_readyH=1
//   rec_readyH     out  byte available, held until acknowledged
//   rec_busyH      out  receiver not idle
//   frame_errH     out  one-cycle pulse on a bad stop bit
//   overrun_errH   out  sticky: a byte was overwritten before it was acked
//   parity_errH    out  parity mismatch on the held byte
//
// state  | meaning
// IDLE   | waiting for a falling edge on an armed line
// START  | validating the start bit (a glitch returns to IDLE)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
// STOP   | resolving the stop bit at its centre
// BREAK  | bad stop bit seen, waiting for the line to return high
module uart_recv #(
  parameter int unsigned CLOCK_DIVIDE = 326,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_I,
  input  logic       uart_REC_dataH,
  input  logic       rec_ackH,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH,
  output logic       rec_busyH,
  output logic       frame_errH,
  output logic       overrun_errH,
  output logic       parity_errH
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  localparam logic [15:0] DIV_LOAD = 16'(CLOCK_DIVIDE - 1);

  state_t      state_q;
  logic        sync1_q, rx_s_q;
  logic        vld1_q, vld2_q, armed_q;
  logic [15:0] div_q;
  logic [3:0]  smp_q;
  logic [2:0]  bit_q;
  logic        v7_q, v8_q;
  logic [7:0]  sr_q, data_q;
  logic        ready_q, ferr_q, ovr_q;

  logic tick, at9, wrap, vote, start_d;

  assign tick    = (div_q == 16'd0);
  assign at9     = tick && (smp_q == 4'd9);
  assign wrap    = tick && (smp_q == 4'd15);
  // The third vote is taken live from rx_s on the count-9 tick.
  assign vote    = (v7_q & v8_q) | (v7_q & rx_s_q) | (v8_q & rx_s_q);
  assign start_d = (state_q == S_IDLE) && armed_q && !rx_s_q;

`ifdef UART_RX_PARITY_EN
  logic par_q, perr_q, par_mis;
  assign par_mis     = par_q ^ (^sr_q) ^ PARITY_ODD;
  assign parity_errH = perr_q;
`else
  // PARITY_ODD has no role without the parity bit.
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign parity_errH       = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_I) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
      div_q   <= DIV_LOAD;
      smp_q   <= 4'd0;
      bit_q   <= 3'd0;
      v7_q    <= 1'b0;
      v8_q    <= 1'b0;
      sr_q    <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= uart_REC_dataH;
      rx_s_q  <= sync1_q;
      // The synchroniser resets to 1; those reset ones are not a real
      // observation of the line, so arming waits until they have flushed.
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      if (vld2_q && rx_s_q) armed_q <= 1'b1;
      ferr_q  <= 1'b0;

      if (start_d || tick) div_q <= DIV_LOAD;
      else                 div_q <= div_q - 16'd1;

      if (state_q != S_IDLE && state_q != S_BREAK && tick) begin
        smp_q <= smp_q + 4'd1;
        if (smp_q == 4'd7) v7_q <= rx_s_q;
        if (smp_q == 4'd8) v8_q <= rx_s_q;
      end

      if (ready_q && rec_ackH) begin
        ready_q <= 1'b0;
        ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_q  <= 1'b0;
`endif
      end

      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q <= S_START;
            smp_q   <= 4'd0;
          end
        end
        S_START: begin
          if (at9 && vote) begin
            state_q <= S_IDLE;
          end else if (wrap) begin
            state_q <= S_DATA;
            bit_q   <= 3'd0;
          end
        end
        S_DATA: begin
          if (at9) sr_q <= {vote, sr_q[7:1]};
          if (wrap) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (at9)  par_q   <= vote;
          if (wrap) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          if (at9) begin
            if (vote) begin
              data_q  <= sr_q;
              ready_q <= 1'b1;
              // An ack landing with completion consumes the old byte.
              ovr_q   <= ready_q && !rec_ackH;
`ifdef UART_RX_PARITY_EN
              perr_q  <= par_mis;
`endif
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rec_dataH    = data_q;
  assign rec_readyH   = ready_q;
  assign rec_busyH    = (state_q != S_IDLE);
  assign frame_errH   = ferr_q;
  assign overrun_errH = ovr_q;

endmodule

// File: tb/tb_uart_recv.sv
`timescale 1ns/1ps
module tb_uart_recv;

  localparam int CD      = 4;
  localparam int BIT_CYC = CD * 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Line driven low between edges E0 and E1. E1 is the start edge, and ready
  // rises 2+9*64+40 edges after it, plus one bit time with a parity bit.
  localparam int LAT = 1 + 2 + 9 * BIT_CYC + 40 + (PAR_EN ? BIT_CYC : 0);

  logic       clk = 1'b0;
  logic       rst_n, rx, ack;
  logic [7:0] rec_dataH;
  logic       rec_readyH, rec_busyH, frame_errH, overrun_errH, parity_errH;

  uart_recv #(.CLOCK_DIVIDE(CD), .PARITY_ODD(1'b0)) dut (
    .sys_clk       (clk),
    .sys_rst_I     (rst_n),
    .uart_REC_dataH(rx),
    .rec_ackH      (ack),
    .rec_dataH     (rec_dataH),
    .rec_readyH    (rec_readyH),
    .rec_busyH     (rec_busyH),
    .frame_errH    (frame_errH),
    .overrun_errH  (overrun_errH),
    .parity_errH   (parity_errH)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         t0;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       flip;
    logic       exp_ready;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  logic prev_ready = 1'b0;
  int   ferr_cycles = 0;
  bit   busy_seen = 0, ready_seen = 0, perr_seen = 0;

  always @(negedge clk) begin
    if (frame_errH)  ferr_cycles++;
    if (rec_busyH)   busy_seen = 1;
    if (rec_readyH)  ready_seen = 1;
    if (parity_errH) perr_seen = 1;
    if (rec_readyH && !prev_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h, expected no byte", rec_dataH);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", rec_dataH, e.data);
        check("parity_err_at_ready", parity_errH, e.perr);
        check("ready_latency", cyc - e.t0, LAT);
      end
    end
    prev_ready = rec_readyH;
  end

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                            input logic expect_byte, input logic perr);
    exp_t e;
    @(negedge clk);
    if (expect_byte) begin
      e.data = d;
      e.perr = perr;
      e.t0   = cyc;
      exp_q.push_back(e);
    end
    send_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CYC);
    if (PAR_EN) send_bit((^d) ^ flip, BIT_CYC);  // even parity, optionally corrupted
    if (stop) send_bit(1'b1, BIT_CYC);
    else      send_bit(1'b0, 200);
    send_bit(1'b1, 16);
  endtask

  task automatic ack_pulse(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_ready_after_ack"}, rec_readyH, 1'b0);
    check({tag, "_overrun_after_ack"}, overrun_errH, 1'b0);
    check({tag, "_parity_after_ack"}, parity_errH, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    int         f0;
    logic [7:0] last_good;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, PAR_EN};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data", rec_dataH, 8'h00);
    check("reset_ready", rec_readyH, 1'b0);
    check("reset_busy", rec_busyH, 1'b0);
    check("reset_frame_err", frame_errH, 1'b0);
    check("reset_overrun", overrun_errH, 1'b0);
    check("reset_parity", parity_errH, 1'b0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_busy", rec_busyH, 1'b0);

    last_good = 8'h00;
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cycles;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].flip, vecs[i].exp_ready, vecs[i].exp_perr);
      check("scoreboard_drained", exp_q.size(), 0);
      check("frame_err_cycles", ferr_cycles - f0, vecs[i].exp_ferr);
      check("ready_level", rec_readyH, vecs[i].exp_ready);
      check("parity_err_level", parity_errH, vecs[i].exp_perr);
      if (vecs[i].exp_ready) begin
        last_good = vecs[i].data;
        ack_pulse("vec");
      end else begin
        check("data_held_on_bad_frame", rec_dataH, last_good);
      end
    end

    // Short low glitch on an idle line.
    f0 = ferr_cycles;
    ready_seen = 0;
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_during", rec_busyH, 1'b1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_cleared", rec_busyH, 1'b0);
    check("glitch_no_ready", ready_seen, 1'b0);
    check("glitch_no_frame_err", ferr_cycles - f0, 0);
    repeat (20) @(negedge clk);

    // Two frames without an ack: the second overwrites the first.
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    check("overrun_data", rec_dataH, 8'h22);
    check("overrun_ready", rec_readyH, 1'b1);
    check("overrun_flag", overrun_errH, 1'b1);
    ack_pulse("overrun");

    // Reset mid-byte with the line held low through and after reset.
    @(negedge clk);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    check("midbyte_busy_before_reset", rec_busyH, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midbyte_reset_busy", rec_busyH, 1'b0);
    check("midbyte_reset_ready", rec_readyH, 1'b0);
    rst_n = 1'b1;
    busy_seen  = 0;
    ready_seen = 0;
    repeat (300) @(negedge clk);
    check("low_line_no_start", busy_seen, 1'b0);
    check("low_line_no_ready", ready_seen, 1'b0);
    rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
    check("post_reset_drained", exp_q.size(), 0);
    check("post_reset_data", rec_dataH, 8'h81);
    ack_pulse("post_reset");

    check("parity_err_ever_seen", perr_seen, PAR_EN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
